// File: rtl/gpu_pkg.sv
// Shared constants, config payload types and pixel helpers for the scope display pipeline.
package gpu_pkg;

  localparam int unsigned H_VIS   = 800;
  localparam int unsigned H_FP    = 40;
  localparam int unsigned H_SYNC  = 128;
  localparam int unsigned H_BP    = 88;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS   = 600;
  localparam int unsigned V_FP    = 1;
  localparam int unsigned V_SYNC  = 4;
  localparam int unsigned V_BP    = 23;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_CNT_W    = 11;
  localparam int unsigned V_CNT_W    = 10;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned RGB_W      = 12;
  localparam int unsigned CFG_ADDR_W = 2;
  localparam int unsigned EN_W       = 3;

  localparam int unsigned EN_GRID   = 0;
  localparam int unsigned EN_WAVE   = 1;
  localparam int unsigned EN_CURSOR = 2;

  localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_GRID   = 2'd0;
  localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_WAVE   = 2'd1;
  localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_CURSOR = 2'd2;
  localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_EN     = 2'd3;

  localparam logic [RGB_W-1:0] DEF_GRID_RGB   = 12'h444;
  localparam logic [RGB_W-1:0] DEF_WAVE_RGB   = 12'h0F0;
  localparam logic [RGB_W-1:0] DEF_CURSOR_RGB = 12'hFF0;
  localparam logic [RGB_W-1:0] BG_RGB         = 12'h000;
  localparam logic [EN_W-1:0]  DEF_EN         = 3'b111;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [RGB_W-1:0]      data;
  } cfg_wr_t;

  typedef struct packed {
    logic [RGB_W-1:0] grid;
    logic [RGB_W-1:0] wave;
    logic [RGB_W-1:0] cursor;
    logic [EN_W-1:0]  en;
  } disp_cfg_t;

  localparam disp_cfg_t DEF_CFG = '{
    grid:   DEF_GRID_RGB,
    wave:   DEF_WAVE_RGB,
    cursor: DEF_CURSOR_RGB,
    en:     DEF_EN
  };

  // Fold one config write into the active configuration.
  function automatic disp_cfg_t cfg_apply(input disp_cfg_t cur, input cfg_wr_t wr);
    disp_cfg_t nxt;
    nxt = cur;
    case (wr.addr)
      CFG_ADDR_GRID:   nxt.grid   = wr.data;
      CFG_ADDR_WAVE:   nxt.wave   = wr.data;
      CFG_ADDR_CURSOR: nxt.cursor = wr.data;
      default:         nxt.en     = wr.data[EN_W-1:0];
    endcase
    return nxt;
  endfunction

  // Fixed-priority layer pick: cursor over wave over grid over background.
  function automatic logic [RGB_W-1:0] layer_pick(input disp_cfg_t cfg, input logic hit_grid,
                                                  input logic hit_wave, input logic hit_cursor);
    logic [RGB_W-1:0] px;
    px = BG_RGB;
    if (cfg.en[EN_CURSOR] && hit_cursor)    px = cfg.cursor;
    else if (cfg.en[EN_WAVE] && hit_wave)   px = cfg.wave;
    else if (cfg.en[EN_GRID] && hit_grid)   px = cfg.grid;
    return px;
  endfunction

endpackage

// File: rtl/gpu_video_timing.sv
// Horizontal/vertical raster counters and the raw timing strobes derived from them.
module gpu_video_timing
  import gpu_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VIS,
  parameter int unsigned H_FRONT   = H_FP,
  parameter int unsigned H_SYNC_W  = H_SYNC,
  parameter int unsigned H_BACK    = H_BP,
  parameter int unsigned V_VISIBLE = V_VIS,
  parameter int unsigned V_FRONT   = V_FP,
  parameter int unsigned V_SYNC_W  = V_SYNC,
  parameter int unsigned V_BACK    = V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               visible,
  output logic               hsync_raw,
  output logic               vsync_raw,
  output logic               vblank_start,
  output logic               frame_origin
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;

  localparam logic [H_CNT_W-1:0] H_LAST    = H_CNT_W'(H_TOT - 1);
  localparam logic [H_CNT_W-1:0] H_VIS_END = H_CNT_W'(H_VISIBLE);
  localparam logic [H_CNT_W-1:0] HS_FIRST  = H_CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_CNT_W-1:0] HS_LAST   = H_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC_W - 1);

  localparam logic [V_CNT_W-1:0] V_LAST    = V_CNT_W'(V_TOT - 1);
  localparam logic [V_CNT_W-1:0] V_VIS_END = V_CNT_W'(V_VISIBLE);
  localparam logic [V_CNT_W-1:0] VS_FIRST  = V_CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_CNT_W-1:0] VS_LAST   = V_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC_W - 1);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;

  // Raster scan: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + H_CNT_W'(1);
    end
  end

  always_comb begin
    visible      = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    row          = visible ? COORD_W'(v_cnt) : '0;
    col          = visible ? h_cnt[COORD_W-1:0] : '0;
    hsync_raw    = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vsync_raw    = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    vblank_start = (h_cnt == '0) && (v_cnt == V_VIS_END);
    frame_origin = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/gpu_display_scheduler.sv
// Display sequencer: drives raster coordinates, composites layer hits into RGB444 and
// holds a one-entry config slot that is committed only at vblank start.
module gpu_display_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VIS,
  parameter int unsigned H_FRONT   = H_FP,
  parameter int unsigned H_SYNC_W  = H_SYNC,
  parameter int unsigned H_BACK    = H_BP,
  parameter int unsigned V_VISIBLE = V_VIS,
  parameter int unsigned V_FRONT   = V_FP,
  parameter int unsigned V_SYNC_W  = V_SYNC,
  parameter int unsigned V_BACK    = V_BP
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [COORD_W-1:0]    row,
  output logic [COORD_W-1:0]    col,
  input  logic                  on_grid,
  input  logic                  on_wave,
  input  logic                  on_cursor,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CFG_ADDR_W-1:0] cfg_addr,
  input  logic [RGB_W-1:0]      cfg_data,
  output logic [RGB_W-1:0]      rgb,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  logic             visible;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             vblank_start;
  logic             frame_origin;
  logic             pending;
  cfg_wr_t          pend_wr;
  disp_cfg_t        active_cfg;
  logic             cfg_accept_c;
  logic [RGB_W-1:0] pixel_c;

  gpu_video_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC_W  (H_SYNC_W),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC_W  (V_SYNC_W),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .row          (row),
    .col          (col),
    .visible      (visible),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .vblank_start (vblank_start),
    .frame_origin (frame_origin)
  );

  assign cfg_ready    = !pending && !rst;
  assign cfg_accept_c = cfg_valid && cfg_ready;

  // Commit and accept are exclusive: accept needs an empty slot, commit needs a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      pend_wr    <= '0;
      active_cfg <= DEF_CFG;
    end else if (vblank_start && pending) begin
      active_cfg <= cfg_apply(active_cfg, pend_wr);
      pending    <= 1'b0;
    end else if (cfg_accept_c) begin
      pending    <= 1'b1;
      pend_wr    <= '{addr: cfg_addr, data: cfg_data};
    end
  end

  assign pixel_c = visible ? layer_pick(active_cfg, on_grid, on_wave, on_cursor) : BG_RGB;

  // Single output stage keeps rgb and the timing strobes aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= pixel_c;
      de          <= visible;
      hsync       <= hsync_raw;
      vsync       <= vsync_raw;
      frame_start <= frame_origin;
    end
  end

endmodule

// File: tb/tb_gpu_display_scheduler.sv
// Directed + randomized bench for gpu_display_scheduler on a shrunken raster, checked
// against a frame-position reference model.
module tb_gpu_display_scheduler;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 10, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk;
  logic        rst;
  logic [9:0]  row, col;
  logic        on_grid, on_wave, on_cursor;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic [11:0] rgb;
  logic        de, hsync, vsync, frame_start;

  gpu_display_scheduler #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC_W(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC_W(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .on_grid(on_grid), .on_wave(on_wave), .on_cursor(on_cursor),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad, cyc, last_fs;

  // Reference model: raster position index, config slot, active colours/enables.
  int          pos;
  bit          m_pend;
  logic [1:0]  m_paddr;
  logic [11:0] m_pdata;
  logic [11:0] m_col [0:2];
  logic [2:0]  m_en;
  logic [11:0] e_rgb;
  bit          e_de, e_hs, e_vs, e_fs;

  // Requester and layer-hit stimulus controls.
  bit          req_active, rand_req;
  logic [1:0]  req_addr;
  logic [11:0] req_data;
  int          on_mode;
  bit          fix_g, fix_w, fix_c;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pos = 0; m_pend = 0; m_paddr = '0; m_pdata = '0;
    m_col[0] = 12'h444; m_col[1] = 12'h0F0; m_col[2] = 12'hFF0; m_en = 3'b111;
    e_rgb = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0;
    last_fs = -1;
  endtask

  task automatic request(input logic [1:0] a, input logic [11:0] d);
    req_active = 1; req_addr = a; req_data = d;
  endtask

  // One clock: check outputs at the falling edge, drive inputs, predict, clock.
  task automatic step(input bit r);
    int h, v;
    bit vis, acc, com;
    h = pos % HT; v = pos / HT;
    vis = (h < HV) && (v < VV);
    check("rgb", rgb, e_rgb);
    check("de", 12'(de), 12'(e_de));
    check("hsync", 12'(hsync), 12'(e_hs));
    check("vsync", 12'(vsync), 12'(e_vs));
    check("frame_start", 12'(frame_start), 12'(e_fs));
    check("row", 12'(row), vis ? 12'(v) : 12'd0);
    check("col", 12'(col), vis ? 12'(h) : 12'd0);
    check("cfg_ready", 12'(cfg_ready), 12'(!m_pend && !rst));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_period", 12'(cyc - last_fs), 12'(FT));
      last_fs = cyc;
    end

    rst = r;
    if (on_mode == 0) begin
      on_grid = 1'($urandom); on_wave = 1'($urandom); on_cursor = 1'($urandom);
    end else begin
      on_grid = fix_g; on_wave = fix_w; on_cursor = fix_c;
    end
    if (rand_req && !req_active && ($urandom % 40 == 0))
      request(2'($urandom), 12'($urandom));
    cfg_valid = req_active && !r;
    cfg_addr  = req_active ? req_addr : 2'($urandom);
    cfg_data  = req_active ? req_data : 12'($urandom);

    if (r) begin
      @(posedge clk);
      model_reset();
      req_active = 0;
    end else begin
      if (!vis) e_rgb = 12'h000;
      else if (m_en[2] && on_cursor) e_rgb = m_col[2];
      else if (m_en[1] && on_wave)   e_rgb = m_col[1];
      else if (m_en[0] && on_grid)   e_rgb = m_col[0];
      else e_rgb = 12'h000;
      e_de = vis;
      e_hs = (h >= HV + HF) && (h < HV + HF + HS);
      e_vs = (v >= VV + VF) && (v < VV + VF + VS);
      e_fs = (pos == 0);
      acc = req_active && !m_pend;
      com = m_pend && (h == 0) && (v == VV);
      @(posedge clk);
      if (com) begin
        if (m_paddr == 2'd3) m_en = m_pdata[2:0];
        else m_col[m_paddr] = m_pdata;
        m_pend = 0;
      end
      if (acc) begin
        m_pend = 1; m_paddr = req_addr; m_pdata = req_data; req_active = 0;
      end
      pos = (pos + 1) % FT;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 2 * FT && pos != p; i++) step(0);
    if (pos != p) begin
      bad++;
      $error("FAIL run_to observed=%0d expected=%0d", pos, p);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * FT && req_active; i++) step(0);
    if (req_active) begin
      bad++;
      $error("FAIL wait_idle observed=busy expected=idle");
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1; on_grid = 0; on_wave = 0; on_cursor = 0;
    cfg_valid = 0; cfg_addr = '0; cfg_data = '0;
    req_active = 0; rand_req = 0; req_addr = '0; req_data = '0;
    on_mode = 0; fix_g = 0; fix_w = 0; fix_c = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held, then free-run two frames with random hits.
    repeat (3) step(1);
    check("ready_in_rst", 12'(cfg_ready), 12'd0);
    step(0);
    check("first_fs", 12'(frame_start), 12'd1);
    run(2 * FT + 5);

    // Wave colour change requested mid-frame lands only on the next frame.
    on_mode = 1; fix_g = 0; fix_w = 1; fix_c = 0;
    run_to(5 * HT + 3);
    request(2'd1, 12'hF00);
    step(0);
    step(0);
    check("ready_drop", 12'(cfg_ready), 12'd0);
    run_to(7 * HT + 2);
    step(0);
    check("wave_old", rgb, 12'h0F0);
    run_to(VV * HT);
    check("ready_held", 12'(cfg_ready), 12'd0);
    step(0);
    check("ready_back", 12'(cfg_ready), 12'd1);
    run_to(0);
    step(0);
    check("wave_new", rgb, 12'hF00);

    // Grid disable, with a second request stalled behind the pending one.
    fix_g = 1; fix_w = 0; fix_c = 0;
    request(2'd3, 12'h006);
    wait_idle();
    request(2'd0, 12'h123);
    run(5);
    check("stall_ready", 12'(cfg_ready), 12'd0);
    check("stall_req", 12'(req_active), 12'd1);
    run_to(0);
    step(0);
    check("grid_off", rgb, 12'h000);
    run_to(0);

    // Random hits and random config traffic.
    on_mode = 0; rand_req = 1;
    run(4 * FT);
    rand_req = 0;
    wait_idle();
    run_to(VV * HT);
    step(0);

    // Reset mid-frame drops the pending write and restores defaults.
    run_to(2 * HT);
    request(2'd2, 12'h00F);
    step(0);
    run_to(7 * HT + 4);
    step(1);
    step(1);
    step(0);
    check("fs_after_rst", 12'(frame_start), 12'd1);
    check("de_after_rst", 12'(de), 12'd1);
    on_mode = 1; fix_g = 1; fix_w = 1; fix_c = 1;
    run_to(HT + 1);
    step(0);
    check("cursor_default", rgb, 12'hFF0);
    on_mode = 0;
    run(FT + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
